// File: rtl/elevator_dispatch.sv
// elevator_dispatch: single-car collective up/down scan controller.
//
// Reads the per-floor call masks from the floor-call register file, moves the
// car one floor per MOVE_CYCLES, stops where the scan says it should, and
// writes a clear word back for every call it serves before opening the door.
//
// Optional feature macro: ELEVATOR_DOOR_HOLD_EN
//   defined   : door_hold held high in DOOR restarts the dwell count each cycle
//   undefined : door_hold is ignored and the dwell is always DOOR_CYCLES
//
// Ports:
//   clk          clock, all state on rising edge
//   reset        asynchronous active-low reset
//   call_inside  in-car call per floor (bit n = floor n)
//   call_up      hall up-call per floor
//   call_down    hall down-call per floor
//   door_hold    door-open button (level)
//   clr_ready    register file accepts clr_data this cycle
//   clr_valid    clear word valid
//   clr_data     clear word {1'b0, up, inside, floor[2:0]}
//   floor        current car floor
//   dir_up       scan direction, 1 = up
//   moving       car travelling between floors
//   door_open    door open
module elevator_dispatch #(
  parameter int unsigned MOVE_CYCLES = 16,
  parameter int unsigned DOOR_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] call_inside,
  input  logic [7:0] call_up,
  input  logic [7:0] call_down,
  input  logic       door_hold,
  input  logic       clr_ready,
  output logic       clr_valid,
  output logic [5:0] clr_data,
  output logic [2:0] floor,
  output logic       dir_up,
  output logic       moving,
  output logic       door_open
);

  // One counter serves both travel and dwell; it only ever counts to max-1.
  localparam int unsigned CntMax = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] MoveLast = CntW'(MOVE_CYCLES - 1);
  localparam logic [CntW-1:0] DoorLast = CntW'(DOOR_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StMove,
    StCheck,
    StClear,
    StDoor
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      floor_q, floor_d;
  logic            dir_q, dir_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Clears still owed at this stop: [0] inside, [1] hall along dir, [2] hall opposite.
  logic [2:0]      todo_q, todo_d;

  logic [7:0] pending, above, below, ahead, behind, beyond_new;
  logic       here, hall_along, stop_go, new_dir;
  logic [2:0] serve;

`ifndef ELEVATOR_DOOR_HOLD_EN
  logic unused_door_hold;
  assign unused_door_hold = door_hold;
`endif

  always_comb begin
    pending = call_inside | call_up | call_down;
    above   = '0;
    below   = '0;
    for (int i = 0; i < 8; i++) begin
      above[i] = pending[i] && (3'(i) > floor_q);
      below[i] = pending[i] && (3'(i) < floor_q);
    end
    ahead      = dir_q ? above : below;
    behind     = dir_q ? below : above;
    here       = pending[floor_q];
    hall_along = dir_q ? call_up[floor_q] : call_down[floor_q];

    // Direction the car leaves a stop with, and the clears that stop owes.
    new_dir    = (|ahead) ? dir_q : ((|behind) ? ~dir_q : dir_q);
    beyond_new = new_dir ? above : below;
    serve[0]   = call_inside[floor_q];
    serve[1]   = new_dir ? call_up[floor_q] : call_down[floor_q];
    serve[2]   = ~(|beyond_new) && (new_dir ? call_down[floor_q] : call_up[floor_q]);
  end

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    todo_d  = todo_q;
    stop_go = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (here) begin
          stop_go = 1'b1;
        end else if (|ahead) begin
          state_d = StMove;
          cnt_d   = '0;
        end else if (|behind) begin
          dir_d   = ~dir_q;
          state_d = StMove;
          cnt_d   = '0;
        end
      end
      StMove: begin
        if (cnt_q == MoveLast) begin
          cnt_d   = '0;
          floor_d = dir_q ? floor_q + 3'd1 : floor_q - 3'd1;
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCheck: begin
        if (call_inside[floor_q] || hall_along || (~(|ahead) && here)) begin
          stop_go = 1'b1;
        end else if (|ahead) begin
          state_d = StMove;
          cnt_d   = '0;
        end else begin
          // Calls withdrawn while travelling: park here rather than run off the end.
          state_d = StIdle;
        end
      end
      StClear: begin
        if (todo_q == 3'b000) begin
          state_d = StDoor;
          cnt_d   = '0;
        end else if (clr_ready) begin
          // Retire the word just accepted (lowest set bit is the one on the bus).
          todo_d = todo_q & 3'(todo_q - 3'd1);
          if (todo_d == 3'b000) begin
            state_d = StDoor;
            cnt_d   = '0;
          end
        end
      end
      StDoor: begin
`ifdef ELEVATOR_DOOR_HOLD_EN
        if (door_hold) begin
          cnt_d = '0;
        end else
`endif
        if (cnt_q == DoorLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (stop_go) begin
      dir_d   = new_dir;
      todo_d  = serve;
      cnt_d   = '0;
      state_d = (|serve) ? StClear : StDoor;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      floor_q <= 3'd0;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
      todo_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      todo_q  <= todo_d;
    end
  end

  always_comb begin
    clr_valid = (state_q == StClear) && (todo_q != 3'b000);
    clr_data  = 6'b000000;
    if (clr_valid) begin
      if (todo_q[0]) begin
        clr_data = {3'b001, floor_q};
      end else if (todo_q[1]) begin
        clr_data = {1'b0, dir_q, 1'b0, floor_q};
      end else begin
        clr_data = {1'b0, ~dir_q, 1'b0, floor_q};
      end
    end
  end

  assign floor     = floor_q;
  assign dir_up    = dir_q;
  assign moving    = (state_q == StMove);
  assign door_open = (state_q == StDoor);

endmodule

// File: tb/tb_elevator_dispatch.sv
// tb_elevator_dispatch: directed self-checking bench for elevator_dispatch
// (MOVE_CYCLES=4, DOOR_CYCLES=6). The bench plays the register file: any
// accepted clear word retires the matching call bit it drives.
module tb_elevator_dispatch;

  localparam int unsigned MoveCycles = 4;
  localparam int unsigned DoorCycles = 6;
`ifdef ELEVATOR_DOOR_HOLD_EN
  localparam logic HoldEn = 1'b1;
`else
  localparam logic HoldEn = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] call_inside;
  logic [7:0] call_up;
  logic [7:0] call_down;
  logic       door_hold;
  logic       clr_ready;
  logic       clr_valid;
  logic [5:0] clr_data;
  logic [2:0] floor;
  logic       dir_up;
  logic       moving;
  logic       door_open;

  int n_assert = 0;
  int n_fail   = 0;

  logic [5:0] clrs[$];
  logic [2:0] acc_floor[$];
  logic       acc_dir[$];

  elevator_dispatch #(
    .MOVE_CYCLES(MoveCycles),
    .DOOR_CYCLES(DoorCycles)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .call_inside(call_inside),
    .call_up    (call_up),
    .call_down  (call_down),
    .door_hold  (door_hold),
    .clr_ready  (clr_ready),
    .clr_valid  (clr_valid),
    .clr_data   (clr_data),
    .floor      (floor),
    .dir_up     (dir_up),
    .moving     (moving),
    .door_open  (door_open)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] clr_at(input int i);
    return (i < clrs.size()) ? clrs[i] : 6'h3f;
  endfunction

  function automatic logic [2:0] floor_at(input int i);
    return (i < acc_floor.size()) ? acc_floor[i] : 3'h7;
  endfunction

  function automatic logic dir_at(input int i);
    return (i < acc_dir.size()) ? acc_dir[i] : 1'bx;
  endfunction

  // One clock: sample the handshake mid-cycle, pass the edge, retire accepted calls.
  task automatic step();
    logic       acc;
    logic [5:0] w;
    #4;
    acc = clr_valid && clr_ready;
    w   = clr_data;
    if (acc) begin
      clrs.push_back(w);
      acc_floor.push_back(floor);
      acc_dir.push_back(dir_up);
    end
    @(posedge clk);
    #1;
    if (acc) begin
      if (w[3])      call_inside[w[2:0]] = 1'b0;
      else if (w[4]) call_up[w[2:0]]     = 1'b0;
      else           call_down[w[2:0]]   = 1'b0;
    end
  endtask

  task automatic clear_log();
    clrs.delete();
    acc_floor.delete();
    acc_dir.delete();
  endtask

  initial begin
    reset       = 1'b1;
    call_inside = 8'h10;
    call_up     = 8'h00;
    call_down   = 8'h00;
    door_hold   = 1'b0;
    clr_ready   = 1'b1;
    #2 reset = 1'b0;

    // Reset held with a call pending.
    repeat (3) step();
    check("rst_floor", 32'(floor), 32'd0);
    check("rst_dir", 32'(dir_up), 32'd1);
    check("rst_moving", 32'(moving), 32'd0);
    check("rst_door", 32'(door_open), 32'd0);
    check("rst_valid", 32'(clr_valid), 32'd0);
    check("rst_data", 32'(clr_data), 32'd0);
    call_inside = 8'h00;
    reset = 1'b1;
    repeat (5) step();
    check("idle_valid", 32'(clr_valid), 32'd0);
    check("idle_moving", 32'(moving), 32'd0);
    check("idle_clrs", 32'(clrs.size()), 32'd0);

    // Inside call to floor 3: three floors of 5 cycles each.
    call_inside = 8'h08;
    step();
    check("t2_move1", 32'(moving), 32'd1);
    repeat (4) step();
    check("t2_floor1", 32'(floor), 32'd1);
    check("t2_check1", 32'(moving), 32'd0);
    repeat (10) step();
    check("t2_floor3", 32'(floor), 32'd3);
    step();
    check("t2_valid", 32'(clr_valid), 32'd1);
    check("t2_data", 32'(clr_data), 32'b001011);
    check("t2_door_pre", 32'(door_open), 32'd0);
    step();
    check("t2_door_first", 32'(door_open), 32'd1);
    repeat (5) step();
    check("t2_door_last", 32'(door_open), 32'd1);
    step();
    check("t2_door_closed", 32'(door_open), 32'd0);
    check("t2_nclr", 32'(clrs.size()), 32'd1);
    check("t2_clr0", 32'(clr_at(0)), 32'b001011);
    check("t2_retired", 32'(call_inside), 32'd0);

    // Back to floor 0, then a collective scan with mixed calls.
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    clear_log();
    call_up     = 8'h04;
    call_down   = 8'h20;
    call_inside = 8'h40;
    for (int k = 0; k < 400 && clrs.size() < 3; k++) step();
    check("t3_nclr", 32'(clrs.size()), 32'd3);
    check("t3_clr0", 32'(clr_at(0)), 32'b010010);
    check("t3_clr1", 32'(clr_at(1)), 32'b001110);
    check("t3_clr2", 32'(clr_at(2)), 32'b000101);
    check("t3_flr0", 32'(floor_at(0)), 32'd2);
    check("t3_flr1", 32'(floor_at(1)), 32'd6);
    check("t3_flr2", 32'(floor_at(2)), 32'd5);
    check("t3_dir0", 32'(dir_at(0)), 32'd1);
    check("t3_dir1", 32'(dir_at(1)), 32'd0);
    step();
    for (int k = 0; k < 50 && door_open; k++) step();
    check("t3_door_closed", 32'(door_open), 32'd0);
    check("t3_floor", 32'(floor), 32'd5);
    check("t3_dir", 32'(dir_up), 32'd0);
    check("t3_calls", 32'({call_inside, call_up, call_down}), 32'd0);

    // Back-pressure at floor 5: inside plus opposite hall call.
    clear_log();
    clr_ready   = 1'b0;
    call_inside = 8'h20;
    call_up     = 8'h20;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("t4_hold_valid%0d", k), 32'(clr_valid), 32'd1);
      check($sformatf("t4_hold_data%0d", k), 32'(clr_data), 32'b001101);
      check($sformatf("t4_hold_door%0d", k), 32'(door_open), 32'd0);
    end
    clr_ready = 1'b1;
    step();
    check("t4_w2_valid", 32'(clr_valid), 32'd1);
    check("t4_w2_data", 32'(clr_data), 32'b010101);
    step();
    check("t4_door", 32'(door_open), 32'd1);
    check("t4_nclr", 32'(clrs.size()), 32'd2);
    check("t4_clr0", 32'(clr_at(0)), 32'b001101);
    check("t4_clr1", 32'(clr_at(1)), 32'b010101);
    check("t4_calls", 32'({call_inside, call_up}), 32'd0);
    repeat (5) step();
    check("t4_door_last", 32'(door_open), 32'd1);
    step();
    check("t4_door_closed", 32'(door_open), 32'd0);

    // Door hold pulsed for three cycles mid-dwell.
    clear_log();
    call_inside = 8'h20;
    step();
    check("t5_valid", 32'(clr_valid), 32'd1);
    step();
    check("t5_door", 32'(door_open), 32'd1);
    step();
    door_hold = 1'b1;
    repeat (3) step();
    door_hold = 1'b0;
    step();
    check("t5_door7", 32'(door_open), 32'd1);
    step();
    check("t5_door8", 32'(door_open), 32'(HoldEn));
    repeat (3) step();
    check("t5_door11", 32'(door_open), 32'(HoldEn));
    step();
    check("t5_door12", 32'(door_open), 32'd0);
    check("t5_nclr", 32'(clrs.size()), 32'd1);

    // Reset asserted while travelling away from floor 4.
    call_inside = 8'h02;
    repeat (7) step();
    check("t6_moving", 32'(moving), 32'd1);
    check("t6_floor4", 32'(floor), 32'd4);
    clear_log();
    reset = 1'b0;
    #1;
    check("t6_floor_async", 32'(floor), 32'd0);
    check("t6_moving_async", 32'(moving), 32'd0);
    check("t6_dir_async", 32'(dir_up), 32'd1);
    check("t6_valid_async", 32'(clr_valid), 32'd0);
    repeat (3) step();
    check("t6_nclr_rst", 32'(clrs.size()), 32'd0);
    call_inside = 8'h00;
    reset = 1'b1;
    repeat (3) step();
    check("t6_idle_moving", 32'(moving), 32'd0);
    check("t6_idle_door", 32'(door_open), 32'd0);
    check("t6_idle_floor", 32'(floor), 32'd0);
    check("t6_nclr", 32'(clrs.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
